// File: rtl/ps2_pkg.sv
// Shared constants, receiver state encoding and the set-2 scan-code to ASCII map
// for the PS/2 keyboard front end.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;
  localparam logic [BYTE_W-1:0] EXT_CODE   = 8'hE0;
  localparam logic [BYTE_W-1:0] LSHIFT     = 8'h12;
  localparam logic [BYTE_W-1:0] RSHIFT     = 8'h59;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef struct packed {
    logic              valid;
    logic [BYTE_W-1:0] ascii;
  } key_t;

  // Letters take the upper- or lower-case base; digits and controls ignore shift.
  function automatic key_t scan_to_ascii(input logic [BYTE_W-1:0] code, input logic shift);
    key_t              r;
    logic [BYTE_W-1:0] base;
    base    = shift ? 8'h41 : 8'h61;
    r.valid = 1'b1;
    r.ascii = 8'h00;
    case (code)
      8'h1C:   r.ascii = base + 8'd0;
      8'h32:   r.ascii = base + 8'd1;
      8'h21:   r.ascii = base + 8'd2;
      8'h23:   r.ascii = base + 8'd3;
      8'h24:   r.ascii = base + 8'd4;
      8'h2B:   r.ascii = base + 8'd5;
      8'h34:   r.ascii = base + 8'd6;
      8'h33:   r.ascii = base + 8'd7;
      8'h43:   r.ascii = base + 8'd8;
      8'h3B:   r.ascii = base + 8'd9;
      8'h42:   r.ascii = base + 8'd10;
      8'h4B:   r.ascii = base + 8'd11;
      8'h3A:   r.ascii = base + 8'd12;
      8'h31:   r.ascii = base + 8'd13;
      8'h44:   r.ascii = base + 8'd14;
      8'h4D:   r.ascii = base + 8'd15;
      8'h15:   r.ascii = base + 8'd16;
      8'h2D:   r.ascii = base + 8'd17;
      8'h1B:   r.ascii = base + 8'd18;
      8'h2C:   r.ascii = base + 8'd19;
      8'h3C:   r.ascii = base + 8'd20;
      8'h2A:   r.ascii = base + 8'd21;
      8'h1D:   r.ascii = base + 8'd22;
      8'h22:   r.ascii = base + 8'd23;
      8'h35:   r.ascii = base + 8'd24;
      8'h1A:   r.ascii = base + 8'd25;
      8'h45:   r.ascii = 8'h30;
      8'h16:   r.ascii = 8'h31;
      8'h1E:   r.ascii = 8'h32;
      8'h26:   r.ascii = 8'h33;
      8'h25:   r.ascii = 8'h34;
      8'h2E:   r.ascii = 8'h35;
      8'h36:   r.ascii = 8'h36;
      8'h3D:   r.ascii = 8'h37;
      8'h3E:   r.ascii = 8'h38;
      8'h46:   r.ascii = 8'h39;
      8'h29:   r.ascii = 8'h20;
      8'h5A:   r.ascii = 8'h0D;
      8'h66:   r.ascii = 8'h08;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises ps2c/ps2d, debounces the clock and
// deserialises start/8 data/parity/stop frames into a one-cycle byte strobe.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_STEPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ps2c,
  input  logic              ps2d,
  output logic              done,
  output logic [BYTE_W-1:0] data
);

  localparam int unsigned CNT_W = 3;

  logic [1:0]              c_sync_q, d_sync_q;
  logic [FILTER_STEPS-1:0] filt_q, filt_d;
  logic                    fclk_q, fclk_d;
  logic                    fall_tick_c;
  logic                    sd_c;

  rx_state_e               state_q, state_d;
  logic [BYTE_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [BYTE_W-1:0]       data_q, data_d;

  assign sd_c = d_sync_q[1];

  // Filtered clock only changes once the whole window agrees; otherwise it holds.
  always_comb begin
    filt_d = {filt_q[FILTER_STEPS-2:0], c_sync_q[1]};
    fclk_d = fclk_q;
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end
    fall_tick_c = fclk_q & ~fclk_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    data_d  = data_q;
    if (fall_tick_c) begin
      unique case (state_q)
        IDLE: begin
          if (en && !sd_c) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {sd_c, shift_q[BYTE_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTE_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          done_d  = 1'b1;
          data_d  = shift_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Lines reset to their idle-high level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q   <= '1;
      fclk_q   <= 1'b1;
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      filt_q   <= filt_d;
      fclk_q   <= fclk_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  assign done = done_q;
  assign data = data_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: frame receiver plus make/break/shift decoder that
// emits a one-cycle done strobe with the ASCII code of each pressed key.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ps2c,
  input  logic              ps2d,
  output logic              done,
  output logic [BYTE_W-1:0] ascii
);

  logic              rx_done;
  logic [BYTE_W-1:0] rx_data;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic              shift_q, shift_d;
  logic              done_q, done_d;
  logic [BYTE_W-1:0] ascii_q, ascii_d;
  logic              is_shift_c;
  key_t              key_c;

  ps2_rx_frame #(
    .FILTER_STEPS(N)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .done (rx_done),
    .data (rx_data)
  );

  // Prefix bytes only update flags; a byte after F0 releases a key silently.
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    ascii_d    = ascii_q;
    is_shift_c = (rx_data == LSHIFT) || (rx_data == RSHIFT);
    key_c      = scan_to_ascii(rx_data, shift_q);
    if (rx_done) begin
      if (rx_data == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (rx_data == EXT_CODE) begin
        ext_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        if (brk_q) begin
          brk_d = 1'b0;
          if (is_shift_c) begin
            shift_d = 1'b0;
          end
        end else if (is_shift_c) begin
          shift_d = 1'b1;
        end else if (key_c.valid) begin
          done_d  = 1'b1;
          ascii_d = key_c.ascii;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      ascii_q <= '0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ascii_q <= ascii_d;
    end
  end

  assign done  = done_q;
  assign ascii = ascii_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised self-checking bench for ps2_keyboard against a behavioural key model.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pc, pd, use2;
  logic       c8, d8, c2, d2;
  logic       done, done2;
  logic [7:0] ascii, ascii2;

  int n_vec  = 0;
  int n_miss = 0;
  int wide   = 0;
  logic done_prev = 1'b0;

  logic [7:0] got[$];
  logic [7:0] got2[$];

  bit m_brk, m_shift;
  int last_ascii;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  always #5 clk = ~clk;

  assign c8 = use2 ? 1'b1 : pc;
  assign d8 = use2 ? 1'b1 : pd;
  assign c2 = use2 ? pc : 1'b1;
  assign d2 = use2 ? pd : 1'b1;

  ps2_keyboard #(.N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ps2c(c8), .ps2d(d8), .done(done), .ascii(ascii)
  );

  ps2_keyboard #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ps2c(c2), .ps2d(d2), .done(done2), .ascii(ascii2)
  );

  always @(negedge clk) begin
    if (done) got.push_back(ascii);
    if (done2) got2.push_back(ascii2);
    if (done && done_prev) wide++;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int map_code(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++) if (letters[i] == c) return (sh ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++) if (digits[i] == c) return 'h30 + i;
    if (c == 8'h29) return 'h20;
    if (c == 8'h5A) return 'h0D;
    if (c == 8'h66) return 'h08;
    return -1;
  endfunction

  function automatic int model_byte(input logic [7:0] b);
    int v = -1;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) v = -1;
    else if (m_brk) begin
      m_brk = 1'b0;
      if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
    end else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
    else v = map_code(b, m_shift);
    return v;
  endfunction

  task automatic ps2_bit(input logic v, input int lo, input int hi, input bit gl);
    pd = v;
    repeat (hi / 2) @(negedge clk);
    pc = 1'b0;
    repeat (lo) @(negedge clk);
    pc = 1'b1;
    if (gl) begin
      repeat (11) @(negedge clk);
      pc = 1'b0;
      repeat (3) @(negedge clk);
      pc = 1'b1;
      repeat (hi - hi / 2 - 14) @(negedge clk);
    end else begin
      repeat (hi - hi / 2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int lo,
                            input int hi, input bit gl, input int enm, input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    if (enm == 1) en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (enm == 2 && i == 4) en = 1'b0;
      ps2_bit(f[i], lo, hi, gl);
    end
    pd = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input logic par, input logic stp, input int lo,
                      input int hi, input bit gl, input int enm);
    int v;
    got.delete();
    send_frame(b, par, stp, lo, hi, gl, enm, 11);
    repeat (30) @(negedge clk);
    en = 1'b1;
    v = (enm == 1) ? -1 : model_byte(b);
    check("done_count", got.size(), (v >= 0) ? 1 : 0);
    if (v >= 0) begin
      last_ascii = v;
      if (got.size() > 0) check("ascii", got[0], v);
    end
    check("ascii_hold", ascii, last_ascii);
  endtask

  task automatic key(input logic [7:0] b);
    xfer(b, ~^b, 1'b1, 10, 10, 1'b0, 0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rst = 1'b0; en = 1'b1; pc = 1'b1; pd = 1'b1; use2 = 1'b0;
    m_brk = 1'b0; m_shift = 1'b0; last_ascii = 0;
    repeat (5) begin
      @(negedge clk);
      check("rst_done", done, 1'b0);
      check("rst_ascii", ascii, 8'h00);
    end
    #4 rst = 1'b1;
    repeat (30) @(negedge clk);
    check("idle_done", got.size(), 0);

    key(8'h1C); key(8'hF0); key(8'h1C);
    xfer(8'hF0, 1'b0, 1'b1, 10, 10, 1'b0, 0);
    key(8'h1C);
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    xfer(8'h1C, 1'b1, 1'b1, 10, 10, 1'b0, 1);
    xfer(8'h1C, 1'b1, 1'b1, 10, 10, 1'b0, 2);
    xfer(8'h2C, ~^8'h2C, 1'b1, 10, 30, 1'b1, 0);
    key(8'hE0); key(8'h1C);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) b = letters[$urandom_range(0, 25)];
      else if (r < 45) b = digits[$urandom_range(0, 9)];
      else if (r < 50) b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h66;
      else if (r < 60) b = 8'hF0;
      else if (r < 65) b = 8'hE0;
      else if (r < 75) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      xfer(b, 1'($urandom), 1'($urandom), 10, 10, 1'b0, (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end

    key(8'hF0);
    got.delete();
    send_frame(8'h1C, 1'b1, 1'b1, 10, 10, 1'b0, 0, 5);
    rst = 1'b0;
    m_brk = 1'b0; m_shift = 1'b0; last_ascii = 0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_done", done, 1'b0);
      check("midrst_ascii", ascii, 8'h00);
    end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_nodone", got.size(), 0);
    key(8'h1C);

    use2 = 1'b1;
    got2.delete();
    send_frame(8'h1C, ~^8'h1C, 1'b1, 4, 4, 1'b0, 0, 11);
    repeat (20) @(negedge clk);
    check("n2_count", got2.size(), 1);
    if (got2.size() > 0) check("n2_ascii", got2[0], 8'h61);

    check("done_width", wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 keyboard front end: filters and deserialises the PS/2 clock/data pair into bytes, then converts make codes into ASCII.
- Emits a one-cycle done strobe with the ASCII value for each key press.
- Sits between the board's PS/2 pins and any character consumer (console, UART bridge).
- Break sequences (F0 xx) are consumed silently.

Parameters:
- N, 8, depth of the ps2c glitch filter in system clocks (minimum 2). The PS/2 low and high phases must each last at least N+2 clocks.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  receive enable; a new frame may start only while en=1
- ps2c  input  1  PS/2 clock from keyboard (asynchronous)
- ps2d  input  1  PS/2 data from keyboard (asynchronous)
- done  output  1  one-cycle strobe: ascii is valid for a newly pressed key
- ascii  output  8  ASCII code of the last pressed key; held until the next done

Behaviour:
- Reset (rst=0, async):
  - done=0, ascii=8'h00.
  - Filter set to idle-high; receiver in IDLE; break, shift and extended flags cleared.
- Synchroniser: ps2c and ps2d each pass through a 2-flop synchroniser.
- Filter:
  - N-bit shift register samples the synchronised ps2c every clock.
  - Filtered clock goes 0 when all N bits are 0, goes 1 when all N bits are 1, otherwise holds.
  - A falling edge of the filtered clock is a one-cycle fall_tick.
- Receiver FSM:
  - IDLE -> DATA on fall_tick with en=1 and ps2d=0 (start bit).
  - fall_tick with ps2d=1, or with en=0, is ignored in IDLE.
  - DATA: on each fall_tick shift ps2d in LSB-first; after 8 data bits -> PARITY.
  - PARITY: on fall_tick capture the parity bit -> STOP. Parity is not checked; frames with even or odd parity are both accepted.
  - STOP: on fall_tick -> IDLE and pulse rx_done for one cycle with rx_data. The stop bit value is not checked.
  - Once a frame has started, en has no effect until the frame completes.
  - No timeout; a truncated frame stalls until further edges arrive or reset.
- Decoder (acts on rx_done):
  - 8'hF0: set break flag; no output.
  - 8'hE0: set extended flag; no output. The flag is cleared by the next byte, which is otherwise decoded normally.
  - Byte received while break flag is set: clear break flag. If the byte is 8'h12 or 8'h59, clear shift. No output.
  - 8'h12 or 8'h59 with no break flag: set shift; no output.
  - Any other mapped make code: on the cycle after rx_done, done=1 for exactly one cycle and ascii is loaded.
  - Unmapped codes produce no done and leave ascii unchanged.
- Scan-code map (set 2):
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a..z (0x61..0x7A); uppercase (0x41..0x5A) when shift is set.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
  - 29 maps to space (0x20), 5A to CR (0x0D), 66 to BS (0x08).
- Latency: done rises 1 clock after rx_done, which is 1 clock after the stop-bit fall_tick.
- Reset mid-frame aborts the frame and clears all flags; no done is produced for it.

Decomposition:
- ps2_pkg holds:
  - constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0, LSHIFT=8'h12, RSHIFT=8'h59;
  - receiver state enum {IDLE, DATA, PARITY, STOP};
  - function scan_to_ascii(code, shift) returning {valid, ascii[7:0]}.
- One sub-module, ps2_rx_frame (parameter FILTER_STEPS=N). It contains the synchroniser, filter and receiver FSM. Ports: clk, rst, en, ps2c, ps2d, done, data[7:0].
- The top level instantiates ps2_rx_frame and holds the decoder registers.

Test Plan:
- Reset: hold rst=0 for 54 ns -> done=0, ascii=00 throughout; release with lines idle high -> no done.
- Sequence 1C, F0, 1C at 20-clock PS/2 period, en=1 during each byte -> exactly one done pulse with ascii=0x61. No done for F0 or for the second 1C.
- Even-parity byte (F0, parity bit 0) -> accepted; break flag set; no done.
- Shift case 12, 1C, F0, 12, 1C -> first done ascii=0x41, second done ascii=0x61.
- en=0 when the start bit falls -> frame ignored, no done. Dropping en mid-frame -> frame still completes.
- Glitch robustness: ps2c low pulse shorter than N clocks inside a high phase -> no extra bit shifted, byte decodes correctly. Also run N=2 with a PS/2 period of 8 clocks -> 1C still yields ascii=0x61.
